hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-002 SHALL have ports `clk`, in, 1, single clock; `rst_n`, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports `id_rs1`/`id_rs2`, in, 5 each, decode-stage source registers.
REQ-004 SHALL have ports `id_uses_rs1`/`id_uses_rs2`, in, 1 each, source actually read.
REQ-005 SHALL have ports `id_ex_MemRead`, in, 1, EX-stage instruction is a load; `id_ex_rd`, in, 5, its destination.
REQ-006 SHALL have port `ex_branch_taken`, in, 1, EX resolved a taken branch or jump.
REQ-007 SHALL have port `ex_md_valid`, in, 1, EX holds a multi-cycle MUL/DIV op.
REQ-008 SHALL have port `md_done`, in, 1, one-cycle completion pulse from the MUL/DIV unit.
REQ-009 SHALL have outputs `pc_we`, `if_id_we`, `id_ex_we`, 1 each, pipeline-register enables.
REQ-010 SHALL have outputs `if_id_flush`, `id_ex_bubble`, `ex_mem_bubble`, 1 each, insert NOP into that register.
REQ-011 SHALL have outputs `md_start`, 1, one-cycle launch pulse; `md_busy`, 1, FSM not IDLE.
REQ-012 SHALL have outputs `stall_cnt`/`flush_cnt`, CNT_W each, present only under the macro (REQ-030).

Function
REQ-013 SHALL implement FSM states IDLE, MD_ISSUE, MD_WAIT.
REQ-014 IDLE with `ex_md_valid`=1 SHALL go to MD_ISSUE; otherwise it SHALL stay in IDLE.
REQ-015 MD_ISSUE SHALL assert `md_start`=1 for exactly that cycle.
REQ-016 MD_ISSUE SHALL go to IDLE if `md_done`=1 in the same cycle, else to MD_WAIT.
REQ-017 MD_WAIT SHALL go to IDLE on `md_done`=1.
REQ-018 `md_done` in IDLE SHALL be ignored.
REQ-019 In MD_ISSUE/MD_WAIT, `pc_we`=`if_id_we`=`id_ex_we`=0 and `ex_mem_bubble`=1.
REQ-020 On the cycle the FSM leaves for IDLE, all enables SHALL be 1 and `ex_mem_bubble`=0, so the op advances.
REQ-021 Load-use SHALL be detected as `id_ex_MemRead` && `id_ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`id_ex_rd`) || (`id_uses_rs2` && `id_rs2`==`id_ex_rd`)).
REQ-022 Load-use in IDLE SHALL give `pc_we`=`if_id_we`=0 and `id_ex_bubble`=1 for that cycle only, which yields a 1-cycle stall.
REQ-023 `ex_branch_taken` SHALL give `if_id_flush`=`id_ex_bubble`=1 with all enables 1.
REQ-024 `ex_branch_taken` SHALL override a simultaneous load-use (no stall).
REQ-025 Priority SHALL be MD hold > branch flush > load-use > normal, where normal is enables 1 and flush/bubble 0.
REQ-026 All control outputs SHALL be combinational from current state and inputs; latency 0.

Reset
REQ-027 `rst_n`=0 at any time SHALL asynchronously force IDLE, including mid MD_WAIT, abandoning the op.
REQ-028 Reset SHALL force `md_start`=0, `md_busy`=0, counters 0.
REQ-029 With reset asserted, the combinational outputs SHALL take their IDLE/no-hazard values: enables 1, flush/bubble 0.

Configuration
REQ-030 Macro `HAZARD_PERF_CNT_EN` SHALL gate the counters.
REQ-031 Defined: `stall_cnt` SHALL increment on each cycle with `pc_we`=0.
REQ-032 Defined: `flush_cnt` SHALL increment on each cycle with `if_id_flush`=1.
REQ-033 Defined: both counters SHALL saturate at all-ones.
REQ-034 Undefined: the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (`hz_state_t`, 2-bit) and the x0 register constant.
REQ-036 One sub-module `hz_perf_cnt` (saturating counter, CNT_W) SHALL be instantiated twice under the macro.

Verification
REQ-037 Load x5, then `id_rs1`=5, `id_uses_rs1`=1 -> one cycle `pc_we`=0, `id_ex_bubble`=1, next cycle normal.
REQ-038 Load with `id_ex_rd`=0, `id_rs1`=0 -> no stall.
REQ-039 `ex_md_valid`=1, `md_done` 4 cycles after `md_start` -> `md_start` 1 cycle, enables 0 for 5 cycles, release on the `md_done` cycle.
REQ-040 `md_done` coincident with `md_start` -> MD_ISSUE straight to IDLE, stall exactly 1 cycle.
REQ-041 `ex_branch_taken`=1 plus load-use hazard -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_we`=1; `flush_cnt`+1.
REQ-042 `rst_n` pulsed low in MD_WAIT -> IDLE immediately, `md_busy`=0, counters 0, late `md_done` ignored.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the hazard control unit: MUL/DIV hold FSM states and the x0 register index.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_ISSUE = 2'd1,
    MD_WAIT  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load into x0 never creates a real dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return mem_read && (ex_rd != REG_X0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_perf_cnt.sv
// hz_perf_cnt: saturating event counter, holds at all-ones.
// Latency: count visible the cycle after the event; no backpressure.
module hz_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stall, branch flush, MUL/DIV hold; HAZARD_PERF_CNT_EN adds counters.
// Latency: all control outputs combinational (0 cycles); no backpressure, MUL/DIV completion via md_done.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_ex_MemRead,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_md_valid,
  input  logic       md_done,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_bubble,
  output logic       md_start,
  output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl_unit: CNT_W must be at least 1");
  end

  hz_state_t state, state_nxt;
  logic      load_use;
  logic      md_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ex_md_valid) state_nxt = MD_ISSUE;
      MD_ISSUE: state_nxt = md_done ? IDLE : MD_WAIT;
      MD_WAIT:  if (md_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign load_use = load_use_hit(id_ex_MemRead, id_ex_rd, id_rs1, id_uses_rs1,
                                 id_rs2, id_uses_rs2);

  // The hold starts in IDLE as soon as EX holds the op and drops on the md_done cycle
  // so the finished op advances out of EX together with the rest of the pipe.
  assign md_hold = (state == IDLE) ? ex_md_valid : !md_done;

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = (state == MD_ISSUE);
    md_busy       = (state != IDLE);
    if (!rst_n) begin
      md_start = 1'b0;
      md_busy  = 1'b0;
    end else if (md_hold) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use && (state == IDLE)) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_we),
    .cnt   (stall_cnt)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: stimulus pushes expected outputs, monitor pops on the falling edge.
module tb_hazard_ctrl_unit;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble, md_start, md_busy}
  localparam logic [7:0] NORM      = 8'b111_000_00;
  localparam logic [7:0] LU        = 8'b001_010_00;
  localparam logic [7:0] BR        = 8'b111_110_00;
  localparam logic [7:0] HOLD_IDLE = 8'b000_001_00;
  localparam logic [7:0] HOLD_ISS  = 8'b000_001_11;
  localparam logic [7:0] HOLD_WAIT = 8'b000_001_01;
  localparam logic [7:0] REL_ISS   = 8'b111_000_11;
  localparam logic [7:0] REL_WAIT  = 8'b111_000_01;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ex_MemRead;
  logic       ex_branch_taken, ex_md_valid, md_done;
  logic       pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic       md_start, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  typedef struct {
    logic [7:0] v;
    bit         rst;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_MemRead   (id_ex_MemRead),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_valid     (ex_md_valid),
    .md_done         (md_done),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .id_ex_we        (id_ex_we),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .md_start        (md_start),
    .md_busy         (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic rstn_v, input logic mdv, input logic mdd, input logic br,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [7:0] exp_v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rstn_v;
    ex_md_valid     = mdv;
    md_done         = mdd;
    ex_branch_taken = br;
    id_ex_MemRead   = mr;
    id_ex_rd        = rd;
    id_rs1          = rs1;
    id_uses_rs1     = u1;
    id_rs2          = rs2;
    id_uses_rs2     = u2;
    e.v   = exp_v;
    e.rst = !rstn_v;
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response.
  initial begin
    exp_t       e;
    logic [7:0] got;
    logic [CNT_W-1:0] exp_stall, exp_flush;
    exp_stall = '0;
    exp_flush = '0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        got = {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble,
               md_start, md_busy};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL ctrl_outputs step %0d: got %b want %b", popped, got, e.v);
        end
        if (e.rst) begin
          exp_stall = '0;
          exp_flush = '0;
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== exp_stall) begin
          errors++;
          $display("FAIL stall_cnt step %0d: got %0d want %0d", popped, stall_cnt, exp_stall);
        end
        checks++;
        if (flush_cnt !== exp_flush) begin
          errors++;
          $display("FAIL flush_cnt step %0d: got %0d want %0d", popped, flush_cnt, exp_flush);
        end
`endif
        if (!e.rst) begin
          if (!e.v[7] && exp_stall != CNT_MAX) exp_stall = exp_stall + 1'b1;
          if (e.v[4] && exp_flush != CNT_MAX) exp_flush = exp_flush + 1'b1;
        end
        popped++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_md_valid = 1'b0; md_done = 1'b0; ex_branch_taken = 1'b0; id_ex_MemRead = 1'b0;
    id_ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

    //   rstn mdv mdd br mr  rd     rs1    u1  rs2    u2  expected
    step(1'b0, 1, 0, 0, 1, 5'd5,  5'd5,  1, 5'd0,  0, NORM);      // reset masks hazards
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);
    step(1'b1, 0, 0, 0, 1, 5'd5,  5'd5,  1, 5'd0,  0, LU);        // load x5, use rs1
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd5,  1, 5'd0,  0, NORM);
    step(1'b1, 0, 0, 0, 1, 5'd7,  5'd3,  1, 5'd7,  1, LU);        // match on rs2
    step(1'b1, 0, 0, 0, 1, 5'd7,  5'd3,  1, 5'd7,  0, NORM);      // rs2 not read
    step(1'b1, 0, 0, 0, 1, 5'd0,  5'd0,  1, 5'd0,  1, NORM);      // load to x0
    step(1'b1, 0, 0, 0, 0, 5'd5,  5'd5,  1, 5'd0,  0, NORM);      // not a load
    step(1'b1, 0, 0, 1, 1, 5'd5,  5'd5,  1, 5'd0,  0, BR);        // branch beats load-use
    step(1'b1, 0, 0, 1, 0, 5'd0,  5'd0,  0, 5'd0,  0, BR);
    step(1'b1, 0, 1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);      // md_done in IDLE ignored
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_IDLE);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_ISS);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_WAIT);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_WAIT);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_WAIT);
    step(1'b1, 1, 1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, REL_WAIT);  // done 4 cycles after start
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_IDLE);
    step(1'b1, 1, 1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, REL_ISS);   // done with start
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);
    step(1'b1, 1, 0, 1, 1, 5'd5,  5'd5,  1, 5'd0,  0, HOLD_IDLE); // MD beats branch and load-use
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_ISS);
    step(1'b1, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, HOLD_WAIT);
    step(1'b0, 1, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);      // reset mid wait
    step(1'b1, 0, 1, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);      // late md_done
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);
    for (int i = 0; i < 18; i++)
      step(1'b1, 0, 0, 0, 1, 5'd9,  5'd2,  0, 5'd9,  1, LU);      // drives stall_cnt to saturation
    for (int i = 0; i < 18; i++)
      step(1'b1, 0, 0, 1, 0, 5'd0,  5'd0,  0, 5'd0,  0, BR);      // drives flush_cnt to saturation
    step(1'b1, 0, 0, 0, 0, 5'd0,  5'd0,  0, 5'd0,  0, NORM);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (popped != pushed) begin
      errors++;
      $display("FAIL drain: got %0d responses want %0d", popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
